// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - 640x480@60 raster timing generator (optional PIX_DIV_EN clock divider)
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       pix_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("video_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       advance;

`ifdef PIX_DIV_EN
    logic div_q, div_d;

    // Divider toggles every clk; the pixel advances on the edge after div==1.
    always_comb begin
        div_d = ~div_q;
    end

    // Divider register, cleared so the first advance lands on the 2nd edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign advance = div_q;
`else
    assign advance = 1'b1;
`endif

    // Next raster position and the outputs derived from it, so every output
    // register updates on the same edge as the counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        hsync_d       = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        active_d      = (x_d < H_ACT) && (y_d < V_ACT);
        line_start_d  = (x_d == 10'd0);
        frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    end

    // Raster state; reset parks on the last pixel so the first advance is (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_tick    = advance;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized self-checking bench for video_timing_gen
module tb_video_timing_gen;

`ifdef PIX_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    localparam int TOT_A = 800 * 525;
    localparam int TOT_B = 12 * 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic       hs_a, vs_a, act_a, ls_a, fs_a, tk_a;
    logic       hs_b, vs_b, act_b, ls_b, fs_b, tk_b;

    int   checks = 0;
    int   failures = 0;
    int   pos_a;
    int   pos_b;
    logic phase;

    always #5 clk = ~clk;

    video_timing_gen dut_a (
        .clk(clk), .reset(reset), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
        .active(act_a), .line_start(ls_a), .frame_start(fs_a), .pix_tick(tk_a)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
        .active(act_b), .line_start(ls_b), .frame_start(fs_b), .pix_tick(tk_b)
    );

    // Expected outputs from a linear pixel index within the frame.
    function automatic logic [25:0] model(input int pos, input int ha, input int hf,
                                          input int hs, input int hb, input int va,
                                          input int vf, input int vs, input logic pol,
                                          input logic tick);
        int ht, xx, yy;
        logic h, v, a, l, f;
        ht = ha + hf + hs + hb;
        xx = pos % ht;
        yy = pos / ht;
        h  = (xx >= ha + hf && xx < ha + hf + hs) ? pol : ~pol;
        v  = (yy >= va + vf && yy < va + vf + vs) ? pol : ~pol;
        a  = (xx < ha) && (yy < va);
        l  = (xx == 0);
        f  = (pos == 0);
        return {10'(xx), 10'(yy), h, v, a, l, f, tick};
    endfunction

    function automatic logic tick_exp();
        return (DIV == 2) ? phase : 1'b1;
    endfunction

    task automatic check_one(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s {x,y,hs,vs,act,ls,fs,tick} observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_one({tag, "/std"}, {x_a, y_a, hs_a, vs_a, act_a, ls_a, fs_a, tk_a},
                  model(pos_a, 640, 16, 96, 48, 480, 10, 2, 1'b0, tick_exp()));
        check_one({tag, "/small"}, {x_b, y_b, hs_b, vs_b, act_b, ls_b, fs_b, tk_b},
                  model(pos_b, 8, 1, 2, 1, 4, 1, 1, 1'b1, tick_exp()));
    endtask

    // One clock: update the reference at the rising edge, compare at the falling edge.
    task automatic step(input string tag);
        logic adv;
        @(posedge clk);
        if (reset) begin
            adv = tick_exp();
            if (DIV == 2) phase = ~phase;
            if (adv) begin
                pos_a = (pos_a + 1) % TOT_A;
                pos_b = (pos_b + 1) % TOT_B;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Assert reset between edges; outputs must return to reset values at once.
    task automatic hit_reset(input string tag);
        reset = 1'b0;
        #1;
        pos_a = TOT_A - 1;
        pos_b = TOT_B - 1;
        phase = 1'b0;
        check_all(tag);
        check_one({tag, "/const"}, {x_a, y_a, hs_a, vs_a, act_a, ls_a, fs_a},
                  {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check_one({tag, "/const_small"}, {x_b, y_b, hs_b, vs_b, act_b, ls_b, fs_b},
                  {10'd11, 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic first_advance(input string tag);
        reset = 1'b1;
        repeat (DIV) step(tag);
        check_one({tag, "/first"}, {x_a, y_a, act_a, ls_a, fs_a},
                  {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
    endtask

    initial begin
        pos_a = TOT_A - 1;
        pos_b = TOT_B - 1;
        phase = 1'b0;
        @(negedge clk);
        hit_reset("reset");
        repeat (3) step("reset_hold");
        first_advance("release");

        repeat (1700 * DIV) step("lines");

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(20, 500)) step("rand_run");
            hit_reset("rand_reset");
            repeat ($urandom_range(1, 3)) step("rand_hold");
            first_advance("rand_restart");
        end

        for (int k = 0; k < 2000 * DIV && pos_a != 700; k++) step("seek");
        checks++;
        assert (x_a === 10'd700) else begin
            failures++;
            $display("FAIL seek_x700 observed=%0d expected=700", x_a);
            $error("seek_x700 observed=%0d", x_a);
        end
        hit_reset("mid_line_reset");
        step("mid_line_hold");
        first_advance("mid_line_restart");
        repeat (900 * DIV) step("after_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
